// File: rtl/fb_port_arbiter_pkg.sv
// Shared definitions for the frame-buffer port arbiter.
// Holds the image geometry, the slot indices, and the row/column to RAM-word
// address helpers shared by the arbiter and its slot timer.
package fb_port_arbiter_pkg;

    localparam int IMG_W   = 320;
    localparam int IMG_H   = 240;
    localparam int DATA_W  = 12;
    localparam int ADDR_W  = 17;
    localparam int SLOTS   = 4;
    localparam int STALL_W = 16;
    localparam int ROW_W   = 8;
    localparam int COL_W   = 9;
    localparam int SLOT_W  = $clog2(SLOTS);

    localparam logic [SLOT_W-1:0] SLOT_VGA  = '0;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);

    localparam logic [ROW_W-1:0] ROW_LIMIT = ROW_W'(IMG_H);
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(IMG_W);

    // Both operands are widened before the multiply so row*IMG_W never wraps.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
    endfunction

    function automatic logic xy_in_range(input logic [ROW_W-1:0] row,
                                         input logic [COL_W-1:0] col);
        return (row < ROW_LIMIT) && (col < COL_LIMIT);
    endfunction

endpackage

// File: rtl/fb_slot_timer.sv
// Slot timer: divides each pixel period into SLOTS clk slots.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   pix_tick      start-of-pixel-period pulse; the clk carrying it is slot 0
//   slot_is_vga   current clk is the reserved VGA read slot
//   slot_is_wr    current clk is one of the writer slots
module fb_slot_timer
    import fb_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pix_tick,
    output logic slot_is_vga,
    output logic slot_is_wr
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] slot_cur;

    // pix_tick overrides the running count in the same clk, so an early tick
    // truncates the period instead of waiting for the wrap.
    assign slot_cur    = pix_tick ? SLOT_VGA : cnt_q;
    assign slot_is_vga = (slot_cur == SLOT_VGA);
    assign slot_is_wr  = ~slot_is_vga;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (slot_cur == SLOT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= slot_cur + 1'b1;
        end
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares the single-port 320x240 RGB444 image RAM
// between the VGA scan-out reader (slot 0 of each pixel period) and the
// masking-engine writer (remaining slots).
// Optional feature macro: VBLANK_WR_EN -- when defined, slot 0 is also given
// to the writer while vga_en is low.
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   pix_tick                   start-of-pixel-period pulse
//   vga_en, vga_row, vga_col   VGA read request (inside image window)
//   vga_pixel                  registered pixel back to the VGA path
//   wr_req, wr_row, wr_col,
//   wr_data                    writer request, held stable until wr_ack
//   wr_ack, wr_err             write consumed / write dropped (bad address)
//   ram_addr, ram_we,
//   ram_wdata, ram_rdata       RAM port; ram_rdata arrives 1 clk after ram_addr
//   stall_cnt                  saturating count of clks a request waited
module fb_port_arbiter
    import fb_port_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_tick,
    input  logic               vga_en,
    input  logic [ROW_W-1:0]   vga_row,
    input  logic [COL_W-1:0]   vga_col,
    output logic [DATA_W-1:0]  vga_pixel,
    input  logic               wr_req,
    input  logic [ROW_W-1:0]   wr_row,
    input  logic [COL_W-1:0]   wr_col,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_ack,
    output logic               wr_err,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_wdata,
    input  logic [DATA_W-1:0]  ram_rdata,
    output logic [STALL_W-1:0] stall_cnt
);

    logic slot_is_vga;
    logic slot_is_wr;
    logic wr_slot_ok;
    logic grant;
    logic vga_rd;
    logic rd_pend;
    logic rd_pend_d;

    fb_slot_timer u_slot_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_tick    (pix_tick),
        .slot_is_vga (slot_is_vga),
        .slot_is_wr  (slot_is_wr)
    );

`ifdef VBLANK_WR_EN
    assign wr_slot_ok = slot_is_wr | (slot_is_vga & ~vga_en);
`else
    assign wr_slot_ok = slot_is_wr;
`endif

    // wr_ack high means a grant went out last clk; the requester has not yet
    // had a chance to move to its next transfer, so it must not be re-granted.
    assign grant  = wr_req & ~wr_ack & wr_slot_ok;
    assign vga_rd = slot_is_vga & vga_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_pixel <= '0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            stall_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_pend_d <= 1'b0;
        end else begin
            ram_we    <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            // rd_pend: address on the RAM; rd_pend_d: data on ram_rdata.
            rd_pend   <= vga_rd;
            rd_pend_d <= rd_pend;

            if (vga_rd) begin
                ram_addr <= xy_to_addr(vga_row, vga_col);
            end else if (grant) begin
                wr_ack <= 1'b1;
                if (xy_in_range(wr_row, wr_col)) begin
                    ram_addr  <= xy_to_addr(wr_row, wr_col);
                    ram_we    <= 1'b1;
                    ram_wdata <= wr_data;
                end else begin
                    wr_err <= 1'b1;
                end
            end

            if (slot_is_vga && !vga_en) begin
                vga_pixel <= '0;
            end
            if (rd_pend_d) begin
                vga_pixel <= ram_rdata;
            end

            // The ack clk is not a stall: that request has already been served.
            if (wr_req && !wr_ack && !grant && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_arbiter.sv
`timescale 1ns/1ps
module tb_fb_port_arbiter;
    import fb_port_arbiter_pkg::*;

`ifdef VBLANK_WR_EN
    localparam bit VBLANK = 1'b1;
`else
    localparam bit VBLANK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pix_tick = 1'b0;
    logic               vga_en = 1'b0;
    logic [ROW_W-1:0]   vga_row = '0;
    logic [COL_W-1:0]   vga_col = '0;
    logic [DATA_W-1:0]  vga_pixel;
    logic               wr_req = 1'b0;
    logic [ROW_W-1:0]   wr_row = '0;
    logic [COL_W-1:0]   wr_col = '0;
    logic [DATA_W-1:0]  wr_data = '0;
    logic               wr_ack;
    logic               wr_err;
    logic [ADDR_W-1:0]  ram_addr;
    logic               ram_we;
    logic [DATA_W-1:0]  ram_wdata;
    logic [DATA_W-1:0]  ram_rdata;
    logic [STALL_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    fb_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_tick  (pix_tick),
        .vga_en    (vga_en),
        .vga_row   (vga_row),
        .vga_col   (vga_col),
        .vga_pixel (vga_pixel),
        .wr_req    (wr_req),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .stall_cnt (stall_cnt)
    );

    // Synchronous single-port RAM attached to the DUT, with a preload port.
    logic [DATA_W-1:0] mem [0:131071];
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0]  m_mem [0:131071];
    int                 m_since;
    logic [DATA_W-1:0]  m_pixel;
    logic [ADDR_W-1:0]  m_addr;
    logic               m_we;
    logic [DATA_W-1:0]  m_wdata;
    logic               m_ack;
    logic               m_err;
    logic [STALL_W-1:0] m_stall;
    bit                 m_rd_issued, m_rd_valid;
    int                 m_rd_addr;
    logic [DATA_W-1:0]  m_rd_cap;
    bit                 m_wpend;
    int                 m_wpend_addr;
    logic [DATA_W-1:0]  m_wpend_data;

    task automatic model_reset();
        m_since = 0; m_pixel = '0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
        m_ack = 1'b0; m_err = 1'b0; m_stall = '0;
        m_rd_issued = 1'b0; m_rd_valid = 1'b0; m_rd_addr = 0; m_rd_cap = '0;
        m_wpend = 1'b0; m_wpend_addr = 0; m_wpend_data = '0;
    endtask

    // One clock edge of the model, using the inputs present during that clk.
    task automatic model_edge();
        int slot;
        bit grantable;
        bit g;
        int r, c;
        slot = pix_tick ? 0 : (m_since % SLOTS);
        if (slot == 0 && !vga_en) m_pixel = '0;
        if (m_rd_valid) m_pixel = m_rd_cap;
        if (m_rd_issued) m_rd_cap = m_mem[m_rd_addr];
        m_rd_valid = m_rd_issued;
        if (m_wpend) m_mem[m_wpend_addr] = m_wpend_data;
        m_wpend = 1'b0;
        grantable = (slot != 0) || (VBLANK && !vga_en);
        g = wr_req && !m_ack && grantable;
        if (wr_req && !m_ack && !g && m_stall != '1) m_stall = m_stall + 1'b1;
        m_we = 1'b0;
        m_err = 1'b0;
        m_rd_issued = (slot == 0) && vga_en;
        if (m_rd_issued) begin
            r = int'(vga_row); c = int'(vga_col);
            m_rd_addr = r * IMG_W + c;
            m_addr = ADDR_W'(m_rd_addr);
        end else if (g) begin
            r = int'(wr_row); c = int'(wr_col);
            if (r < IMG_H && c < IMG_W) begin
                m_addr = ADDR_W'(r * IMG_W + c);
                m_we = 1'b1;
                m_wdata = wr_data;
                m_wpend = 1'b1;
                m_wpend_addr = r * IMG_W + c;
                m_wpend_data = wr_data;
            end else begin
                m_err = 1'b1;
            end
        end
        m_ack = g;
        m_since = pix_tick ? 1 : m_since + 1;
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("vga_pixel", vga_pixel, m_pixel);
            check("ram_addr", ram_addr, m_addr);
            check("ram_we", ram_we, m_we);
            check("ram_wdata", ram_wdata, m_wdata);
            check("wr_ack", wr_ack, m_ack);
            check("wr_err", wr_err, m_err);
            check("stall_cnt", stall_cnt, m_stall);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } wr_t;
    wr_t wq[$];
    int  cnt = 0;

    task automatic present();
        if (wq.size() > 0) begin
            wr_req = 1'b1; wr_row = wq[0].row; wr_col = wq[0].col; wr_data = wq[0].data;
        end else begin
            wr_req = 1'b0;
        end
    endtask

    task automatic push(input int r, input int c, input int d);
        wq.push_back('{ROW_W'(r), COL_W'(c), DATA_W'(d)});
        present();
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        cnt++;
        pix_tick = (cnt % SLOTS == 0);
        if (wr_ack && wq.size() > 0) wq.delete(0);
        present();
    endtask

    task automatic align();
        while (cnt % SLOTS != 0) cyc();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && wq.size() > 0; i++) cyc();
        check(name, wq.size(), 0);
        cyc();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt = 0;
        pix_tick = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic preload(input int a, input int d);
        ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_data = DATA_W'(d);
        m_mem[a] = DATA_W'(d);
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    int ack_at[$];

    initial begin
        for (int i = 0; i < 131072; i++) m_mem[i] = '0;
        model_reset();
        preload(0, 'h111);
        preload(645, 'hABC);
        preload(320, 'h000);
        preload(1, 'h000);

        check("rst_vga_pixel", vga_pixel, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_wr_ack", wr_ack, 0);
        check("rst_stall", stall_cnt, 0);
        release_reset();

        // reset in the middle of a write
        vga_en = 1'b1; vga_row = 0; vga_col = 0;
        push(0, 1, 'h123);
        cyc();
        cyc();
        check("t1_we_before_rst", ram_we, 1);
        check("t1_addr_before_rst", ram_addr, 1);
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t1_rst_ram_we", ram_we, 0);
        check("t1_rst_wr_ack", wr_ack, 0);
        check("t1_rst_stall", stall_cnt, 0);
        wq.delete();
        present();
        model_reset();
        release_reset();

        // VGA read of (2,5)
        vga_en = 1'b1; vga_row = 2; vga_col = 5;
        cyc();
        check("t2_addr", ram_addr, 645);
        check("t2_we", ram_we, 0);
        cyc();
        cyc();
        check("t2_pixel", vga_pixel, 'hABC);

        // single write (1,0) waits through slot 0
        align();
        push(1, 0, 'hF00);
        cyc();
        cyc();
        check("t3_ack", wr_ack, 1);
        check("t3_we", ram_we, 1);
        check("t3_addr", ram_addr, 320);
        check("t3_wdata", ram_wdata, 'hF00);
        cyc();
        check("t3_ack_pulse", wr_ack, 0);
        check("t3_stall", stall_cnt, 1);

        // read back what was written
        align();
        vga_row = 1; vga_col = 0;
        cyc(); cyc(); cyc();
        check("t3_readback", vga_pixel, 'hF00);

        // three queued writes
        align();
        push(5, 5, 'h101);
        push(5, 6, 'h202);
        push(5, 7, 'h303);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (wr_ack) ack_at.push_back(i);
        end
        check("t4_nacks", ack_at.size(), 3);
        if (ack_at.size() == 3) begin
            check("t4_ack0", ack_at[0], 2);
            check("t4_ack1", ack_at[1], 4);
            check("t4_ack2", ack_at[2], 6);
        end
        check("t4_drained", wq.size(), 0);

        // address range boundaries
        align();
        push(240, 10, 'h777);
        cyc();
        cyc();
        check("t5_ack", wr_ack, 1);
        check("t5_err", wr_err, 1);
        check("t5_we", ram_we, 0);
        drain("t5_drain");
        align();
        push(239, 319, 'h5A5);
        cyc();
        cyc();
        check("t5_last_addr", ram_addr, 76799);
        check("t5_last_we", ram_we, 1);
        check("t5_last_err", wr_err, 0);
        drain("t5_last_drain");
        push(0, 320, 'h777);
        drain("t5_col_drain");

        // early pix_tick truncates the period; the write waits
        align();
        cyc();
        cyc();
        pix_tick = 1'b1;
        push(7, 7, 'h4C4);
        cyc();
        check("t7_no_grant_slot0", wr_ack, 0);
        cyc();
        check("t7_grant_after", wr_ack, 1);
        drain("t7_drain");

        // blanking: slot 0 idle or writer slot
        vga_en = 1'b0;
        align();
        push(3, 7, 'h0F0);
        cyc();
        check("t6_black", vga_pixel, 0);
        if (VBLANK) begin
            check("t6_slot0_ack", wr_ack, 1);
            check("t6_slot0_addr", ram_addr, 967);
        end else begin
            check("t6_slot0_noack", wr_ack, 0);
            check("t6_slot0_nowe", ram_we, 0);
        end
        drain("t6_drain");

        // blanking burst
        align();
        push(9, 1, 'h011);
        push(9, 2, 'h022);
        push(9, 3, 'h033);
        push(9, 4, 'h044);
        drain("t6_burst_drain");
        vga_en = 1'b1; vga_row = 3; vga_col = 7;
        align();
        cyc(); cyc(); cyc();
        check("t6_readback", vga_pixel, 'h0F0);
        cyc(); cyc();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
